master_bus_condition_generator: RTL and testbench

Master-side bit-level I2C engine: the transmitting counterpart of the slave start/stop detector. It generates START, repeated START and STOP conditions and single data bits (write or read) on open-drain SCL/SDA, from a command handshake. The master byte controller sits above it; the pad open-drain drivers sit below it.

---
 rtl/master_i2c_pkg.sv | 65 ++++++
 rtl/master_quarter_timer.sv | 28 ++
 rtl/master_bus_condition_generator.sv | 142 ++++++++++++++
 tb/tb_master_bus_condition_generator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/master_i2c_pkg.sv
// Shared definitions for the master I2C bit engine: command codes, FSM states,
// quarter phases and the SCL/SDA level table (1 = released, 0 = pulled low).
package master_i2c_pkg;

  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_START,
    ST_STOP,
    ST_WRITE,
    ST_READ
  } state_t;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quarter_t;

  typedef struct packed {
    logic scl;
    logic sda;
  } levels_t;

  function automatic state_t cmd_state(input logic [2:0] cmd);
    case (cmd)
      CMD_START: return ST_START;
      CMD_STOP:  return ST_STOP;
      CMD_WRITE: return ST_WRITE;
      CMD_READ:  return ST_READ;
      default:   return ST_IDLE;
    endcase
  endfunction

  // START Q0 keeps SCL where it is, so a repeated START never glitches SCL high early.
  function automatic levels_t bus_levels(input state_t st, input quarter_t q,
                                         input logic data_bit, input logic scl_now);
    levels_t lv;
    lv = '{scl: scl_now, sda: 1'b1};
    case (st)
      ST_START: begin
        case (q)
          Q0: lv = '{scl: scl_now, sda: 1'b1};
          Q1: lv = '{scl: 1'b1,    sda: 1'b1};
          Q2: lv = '{scl: 1'b1,    sda: 1'b0};
          Q3: lv = '{scl: 1'b0,    sda: 1'b0};
        endcase
      end
      ST_STOP: begin
        case (q)
          Q0: lv = '{scl: 1'b0, sda: 1'b0};
          Q1: lv = '{scl: 1'b1, sda: 1'b0};
          Q2: lv = '{scl: 1'b1, sda: 1'b1};
          Q3: lv = '{scl: 1'b1, sda: 1'b1};
        endcase
      end
      ST_WRITE: lv = '{scl: (q == Q1) || (q == Q2), sda: data_bit};
      ST_READ:  lv = '{scl: (q == Q1) || (q == Q2), sda: 1'b1};
      default:  lv = '{scl: scl_now, sda: 1'b1};
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/master_quarter_timer.sv
// Quarter-period down-counter: reloads QUARTER_DIV-1, pulses quarter_done on wrap.
// Latency: quarter_done in the QUARTER_DIV-th counting cycle after run rises.
// Backpressure: stretch freezes the count; dropping run reloads it.
module master_quarter_timer #(
  parameter int unsigned QUARTER_DIV = 25
) (
  input  logic master_clock,
  input  logic master_reset,
  input  logic run,
  input  logic stretch,
  output logic quarter_done
);

  localparam logic [15:0] RELOAD = 16'(QUARTER_DIV - 1);

  logic [15:0] count_q;

  always_ff @(posedge master_clock) begin
    if (master_reset || !run) begin
      count_q <= RELOAD;
    end else if (!stretch) begin
      count_q <= (count_q == 16'd0) ? RELOAD : count_q - 16'd1;
    end
  end

  assign quarter_done = run & ~stretch & (count_q == 16'd0);

endmodule

// File: rtl/master_bus_condition_generator.sv
// Master I2C bit engine: START/STOP/repeated START and single data bits on open-drain SCL/SDA.
// Latency: rsp_valid 1+4*QUARTER_DIV cycles after acceptance, plus any SCL stretch time.
// Backpressure: cmd_ready low while a command is in flight; slaves stretch by holding SCL low.
module master_bus_condition_generator
  import master_i2c_pkg::*;
#(
  parameter int unsigned QUARTER_DIV = 25
) (
  input  logic       master_clock,
  input  logic       master_reset,
  input  logic       master_cmd_valid,
  output logic       master_cmd_ready,
  input  logic [2:0] master_cmd,
  input  logic       master_cmd_bit,
  output logic       master_rsp_valid,
  output logic       master_rsp_bit,
  output logic       master_cmd_err,
  output logic       master_bus_owned,
  input  logic       master_scl_in,
  input  logic       master_sda_in,
  output logic       master_scl_oe,
  output logic       master_sda_oe
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_s;
  logic       sda_s;

  state_t     state_q;
  quarter_t   quarter_q;
  logic       cmd_bit_q;
  logic       sample_q;
  logic [1:0] settle_q;

  logic       busy;
  logic       is_data;
  logic       stretch;
  logic       quarter_done;
  logic       cmd_ok;

  state_t     load_state;
  quarter_t   load_quarter;
  logic       load_bit;
  levels_t    load_lv;

  always_ff @(posedge master_clock) begin
    if (master_reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], master_scl_in};
      sda_sync_q <= {sda_sync_q[0], master_sda_in};
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign busy    = state_q inside {ST_START, ST_STOP, ST_WRITE, ST_READ};
  assign is_data = (state_q == ST_WRITE) || (state_q == ST_READ);

  // Right after SCL is released the synchroniser still shows the old low level;
  // settle_q masks those cycles so an unstretched quarter stays exactly QUARTER_DIV.
  assign stretch = busy & ~master_scl_oe & ~scl_s & (settle_q == 2'd0);

  assign cmd_ok = (master_cmd == CMD_START) ||
                  (master_bus_owned && ((master_cmd == CMD_STOP) ||
                                        (master_cmd == CMD_WRITE) ||
                                        (master_cmd == CMD_READ)));

  always_comb begin
    load_state   = busy ? state_q : cmd_state(master_cmd);
    load_quarter = busy ? quarter_t'(quarter_q + 2'd1) : Q0;
    load_bit     = busy ? cmd_bit_q : master_cmd_bit;
    load_lv      = bus_levels(load_state, load_quarter, load_bit, ~master_scl_oe);
  end

  master_quarter_timer #(
    .QUARTER_DIV (QUARTER_DIV)
  ) u_timer (
    .master_clock (master_clock),
    .master_reset (master_reset),
    .run          (busy),
    .stretch      (stretch),
    .quarter_done (quarter_done)
  );

  always_ff @(posedge master_clock) begin
    if (master_reset) begin
      state_q          <= ST_IDLE;
      quarter_q        <= Q0;
      cmd_bit_q        <= 1'b0;
      sample_q         <= 1'b0;
      settle_q         <= 2'd0;
      master_cmd_ready <= 1'b1;
      master_rsp_valid <= 1'b0;
      master_rsp_bit   <= 1'b0;
      master_cmd_err   <= 1'b0;
      master_bus_owned <= 1'b0;
      master_scl_oe    <= 1'b0;
      master_sda_oe    <= 1'b0;
    end else begin
      master_rsp_valid <= 1'b0;
      master_cmd_err   <= 1'b0;
      if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;

      if (busy) begin
        if (quarter_done) begin
          if (quarter_q == Q2 && is_data) sample_q <= sda_s;
          if (quarter_q == Q3) begin
            // Bus levels stay as Q3 left them: HOLD keeps SCL low, STOP leaves both released.
            master_rsp_valid <= 1'b1;
            master_cmd_ready <= 1'b1;
            master_rsp_bit   <= is_data & sample_q;
            state_q          <= (state_q == ST_STOP) ? ST_IDLE : ST_HOLD;
            if (state_q == ST_START) master_bus_owned <= 1'b1;
            else if (state_q == ST_STOP) master_bus_owned <= 1'b0;
          end else begin
            quarter_q     <= load_quarter;
            master_scl_oe <= ~load_lv.scl;
            master_sda_oe <= ~load_lv.sda;
            if (master_scl_oe && load_lv.scl) settle_q <= 2'd2;
          end
        end
      end else if (master_cmd_valid && master_cmd_ready) begin
        if (cmd_ok) begin
          state_q          <= load_state;
          quarter_q        <= Q0;
          cmd_bit_q        <= master_cmd_bit;
          master_cmd_ready <= 1'b0;
          master_scl_oe    <= ~load_lv.scl;
          master_sda_oe    <= ~load_lv.sda;
          if (master_scl_oe && load_lv.scl) settle_q <= 2'd2;
        end else begin
          master_cmd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_master_bus_condition_generator.sv
// Directed bench: command table with hand-computed latency/response/ownership,
// plus hand sequences for reset behaviour and bus waveform shape (QUARTER_DIV=4).
module tb_master_bus_condition_generator;
  import master_i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd = 3'd0;
  logic       cmd_bit = 1'b0;
  logic       rsp_valid;
  logic       rsp_bit;
  logic       cmd_err;
  logic       bus_owned;
  logic       scl_oe;
  logic       sda_oe;
  logic       ext_scl_low = 1'b0;
  logic       ext_sda_low = 1'b0;
  logic       scl_pad;
  logic       sda_pad;

  assign scl_pad = ~scl_oe & ~ext_scl_low;
  assign sda_pad = ~sda_oe & ~ext_sda_low;

  always #5 clk = ~clk;

  master_bus_condition_generator #(.QUARTER_DIV(4)) dut (
    .master_clock     (clk),
    .master_reset     (rst),
    .master_cmd_valid (cmd_valid),
    .master_cmd_ready (cmd_ready),
    .master_cmd       (cmd),
    .master_cmd_bit   (cmd_bit),
    .master_rsp_valid (rsp_valid),
    .master_rsp_bit   (rsp_bit),
    .master_cmd_err   (cmd_err),
    .master_bus_owned (bus_owned),
    .master_scl_in    (scl_pad),
    .master_sda_in    (sda_pad),
    .master_scl_oe    (scl_oe),
    .master_sda_oe    (sda_oe)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] cmd;
    logic       cbit;
    logic       sda_pull;
    int         stretch;
    int         exp_lat;
    logic       exp_bit;
    logic       exp_err;
    logic       exp_owned;
  } vec_t;

  vec_t vecs[14];

  int   lat, err_n, err_cnt;
  logic rbit, oe_any, owned_min, rdy_rsp;
  logic sc_log[64];
  logic sd_log[64];
  logic own_log[64];

  // Offer one command, then watch up to 60 cycles; n counts cycles after the accepting edge.
  task automatic run_cmd(input logic [2:0] c, input logic b, input logic pull, input int str);
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd = c;
    cmd_bit = b;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = -1; err_n = -1; err_cnt = 0;
    oe_any = 1'b0; owned_min = 1'b1; rbit = 1'b0; rdy_rsp = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      sc_log[n] = scl_pad;
      sd_log[n] = sda_pad;
      own_log[n] = bus_owned;
      ext_sda_low = pull && (n >= 5) && (n <= 12);
      ext_scl_low = (str > 0) && (n >= 5) && (n < 5 + str);
      if (cmd_err) begin
        err_cnt++;
        if (err_n < 0) err_n = n;
      end
      if (scl_oe || sda_oe) oe_any = 1'b1;
      if (!bus_owned) owned_min = 1'b0;
      if (rsp_valid) begin
        lat = n;
        rbit = rsp_bit;
        rdy_rsp = cmd_ready;
        break;
      end
      @(negedge clk);
    end
    ext_sda_low = 1'b0;
    ext_scl_low = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{CMD_START, 1'b0, 1'b0, 0,  17, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{CMD_WRITE, 1'b1, 1'b1, 0,  17, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{CMD_READ,  1'b0, 1'b0, 0,  17, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{CMD_WRITE, 1'b1, 1'b0, 10, 27, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{CMD_WRITE, 1'b0, 1'b0, 0,  17, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{CMD_START, 1'b0, 1'b0, 0,  17, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'd5,      1'b0, 1'b0, 0,  -1, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{CMD_STOP,  1'b0, 1'b0, 0,  17, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{CMD_WRITE, 1'b1, 1'b0, 0,  -1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{CMD_READ,  1'b0, 1'b0, 0,  -1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{CMD_STOP,  1'b0, 1'b0, 0,  -1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd0,      1'b0, 1'b0, 0,  -1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{CMD_START, 1'b0, 1'b0, 0,  17, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{CMD_READ,  1'b0, 1'b1, 0,  17, 1'b0, 1'b0, 1'b1};

    // A command offered during reset must not be taken.
    repeat (2) @(negedge clk);
    cmd_valid = 1'b1;
    cmd = CMD_START;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_bit", rsp_bit, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_bus_owned", bus_owned, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    @(negedge clk);
    chk("rst_offer_ignored_scl", scl_oe | sda_oe, 0);
    chk("rst_offer_ignored_ready", cmd_ready, 1);

    for (int i = 0; i < 14; i++) begin
      run_cmd(vecs[i].cmd, vecs[i].cbit, vecs[i].sda_pull, vecs[i].stretch);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_err_cycle", i), err_n, vecs[i].exp_err ? 1 : -1);
      chk($sformatf("v%0d_bus_owned", i), bus_owned, vecs[i].exp_owned);
      if (vecs[i].exp_lat > 0) begin
        chk($sformatf("v%0d_rsp_bit", i), rbit, vecs[i].exp_bit);
        chk($sformatf("v%0d_ready_at_rsp", i), rdy_rsp, 1);
      end
      if (vecs[i].exp_err) chk($sformatf("v%0d_err_pulses", i), err_cnt, 1);
      if (vecs[i].exp_err && !vecs[i].exp_owned) chk($sformatf("v%0d_no_bus_activity", i), oe_any, 0);
      if (i == 0) begin
        chk("start_q1_levels", {sc_log[8], sd_log[8]}, 2'b11);
        chk("start_q2_first", {sc_log[9], sd_log[9]}, 2'b10);
        chk("start_q2_last", {sc_log[12], sd_log[12]}, 2'b10);
        chk("start_q3_levels", {sc_log[13], sd_log[13]}, 2'b00);
        chk("start_owned_before_rsp", own_log[16], 0);
        chk("start_owned_at_rsp", own_log[17], 1);
      end
      if (i == 5) begin
        chk("rstart_q0_levels", {sc_log[4], sd_log[4]}, 2'b01);
        chk("rstart_q1_levels", {sc_log[8], sd_log[8]}, 2'b11);
        chk("rstart_q2_levels", {sc_log[9], sd_log[9]}, 2'b10);
        chk("rstart_owned_throughout", owned_min, 1);
      end
      if (i == 7) begin
        chk("stop_q0_levels", {sc_log[4], sd_log[4]}, 2'b00);
        chk("stop_q1_levels", {sc_log[8], sd_log[8]}, 2'b10);
        chk("stop_q2_levels", {sc_log[9], sd_log[9]}, 2'b11);
        chk("stop_owned_before_rsp", own_log[16], 1);
      end
    end

    // Reset in the middle of READ Q2 (cycles 9..12 after acceptance).
    @(negedge clk);
    chk("midrst_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd = CMD_READ;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_still_busy", cmd_ready, 0);
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd = CMD_START;
    @(negedge clk);
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_owned", bus_owned, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst_no_accept", scl_oe | sda_oe, 0);

    run_cmd(CMD_START, 1'b0, 1'b0, 0);
    chk("post_rst_start_latency", lat, 17);
    chk("post_rst_start_owned", bus_owned, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
